// File: rtl/bytebeat_audio_pkg.sv
// Shared types and helpers for the bytebeat PCM-to-PWM output stage.
package bytebeat_audio_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_SELECT = 2'd1,
    MODE_MIX    = 2'd2,
    MODE_MUTE   = 2'd3
  } mode_e;

  // Half-scale level: 50% duty.
  function automatic int unsigned mid_level(input int unsigned sw);
    return 32'd1 << (sw - 1);
  endfunction

  // LSB position of channel ch in a packed sample bus.
  function automatic int unsigned sample_lsb(input int unsigned ch, input int unsigned sw);
    return ch * sw;
  endfunction

endpackage

// File: rtl/bytebeat_sample_slot.sv
// One-entry sample buffer per channel: accepts on valid/ready, transfers to the
// active sample on tick, and flags underrun when a tick finds the buffer empty.
module bytebeat_sample_slot
  import bytebeat_audio_pkg::*;
#(
  parameter int unsigned SW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          vld_i,
  input  logic [SW-1:0] data_i,
  input  logic          clr_i,
  output logic          rdy_o,
  output logic [SW-1:0] active_o,
  output logic          underrun_o
);

  localparam logic [SW-1:0] Mid = SW'(mid_level(SW));

  logic [SW-1:0] buf_q, buf_d;
  logic [SW-1:0] active_q, active_d;
  logic          full_q, full_d;
  logic          underrun_q, underrun_d;

  always_comb begin
    buf_d      = buf_q;
    active_d   = active_q;
    full_d     = full_q;
    underrun_d = underrun_q;
    // A full slot never accepts, so drain and accept are mutually exclusive.
    if (tick_i && full_q) begin
      active_d = buf_q;
      full_d   = 1'b0;
    end else if (vld_i && !full_q) begin
      buf_d  = data_i;
      full_d = 1'b1;
    end
    if (clr_i) underrun_d = 1'b0;
    if (tick_i && !full_q) underrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q      <= '0;
      active_q   <= Mid;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      active_q   <= active_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign rdy_o      = !full_q;
  assign active_o   = active_q;
  assign underrun_o = underrun_q;

endmodule

// File: rtl/bytebeat_audio_out.sv
// Multi-channel PCM-to-PWM output stage: sample-rate tick, per-channel sample
// slots, mode-dependent level selection and PWM compare against a free carrier.
module bytebeat_audio_out
  import bytebeat_audio_pkg::*;
#(
  parameter int unsigned NCH   = 8,
  parameter int unsigned SW    = 8,
  parameter int unsigned DIV_W = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [1:0]              mode_i,
  input  logic [$clog2(NCH)-1:0]  sel_i,
  input  logic [NCH*SW-1:0]       pcm_in_i,
  input  logic [NCH-1:0]          pcm_vld_i,
  output logic [NCH-1:0]          pcm_rdy_o,
  input  logic                    clr_underrun_i,
  output logic                    tick_o,
  output logic [NCH-1:0]          pwm_out_o,
  output logic [NCH-1:0]          underrun_o
);

  localparam int unsigned   Lg   = $clog2(NCH);
  localparam int unsigned   SumW = SW + Lg;
  localparam logic [SW-1:0] Mid  = SW'(mid_level(SW));

  mode_e mode;
  assign mode = mode_e'(mode_i);

  // Sample-rate tick; >= lets a shrinking divider wrap immediately.
  logic [DIV_W-1:0] tcnt_q, tcnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tcnt_d = tcnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (tcnt_q >= div_i) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  logic [SW-1:0] active [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    bytebeat_sample_slot #(
      .SW(SW)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick_q),
      .vld_i      (pcm_vld_i[i]),
      .data_i     (pcm_in_i[sample_lsb(i, SW) +: SW]),
      .clr_i      (clr_underrun_i),
      .rdy_o      (pcm_rdy_o[i]),
      .active_o   (active[i]),
      .underrun_o (underrun_o[i])
    );
  end

  logic [SumW-1:0] sum;
  logic [SW-1:0]   mix;
  logic [SW-1:0]   target [NCH];

  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++) sum = sum + SumW'(active[i]);
    mix = SW'(sum >> Lg);
    for (int i = 0; i < NCH; i++) begin
      target[i] = Mid;
      unique case (mode)
        MODE_DIRECT: target[i] = active[i];
        MODE_SELECT: target[i] = active[sel_i];
        MODE_MIX:    target[i] = mix;
        MODE_MUTE:   target[i] = Mid;
        default:     target[i] = Mid;
      endcase
    end
  end

  logic [SW-1:0]  carrier_q;
  logic [SW-1:0]  level_q [NCH];
  logic [SW-1:0]  level_d [NCH];
  logic [NCH-1:0] pwm_q, pwm_d;

  // Levels only move at the carrier wrap so no period is ever truncated.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      level_d[i] = (carrier_q == {SW{1'b1}}) ? target[i] : level_q[i];
      pwm_d[i]   = carrier_q < level_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      carrier_q <= '0;
      pwm_q     <= '0;
      for (int i = 0; i < NCH; i++) level_q[i] <= Mid;
    end else begin
      carrier_q <= carrier_q + SW'(1);
      pwm_q     <= pwm_d;
      for (int i = 0; i < NCH; i++) level_q[i] <= level_d[i];
    end
  end

  assign pwm_out_o = pwm_q;

endmodule

// File: tb/tb_bytebeat_audio_out.sv
// Bench for bytebeat_audio_out (NCH=4, SW=8): directed steps plus random traffic
// against a cycle-level reference model built from the behavioural rules.
module tb_bytebeat_audio_out;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  div;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [31:0] pcm_in;
  logic [3:0]  pcm_vld;
  logic [3:0]  pcm_rdy;
  logic        clr;
  logic        tick;
  logic [3:0]  pwm;
  logic [3:0]  und;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  int m_tcnt;
  bit m_tick;
  bit m_full [NCH];
  int m_buf  [NCH];
  int m_act  [NCH];
  bit m_und  [NCH];
  int m_car;
  int m_lvl  [NCH];
  bit m_pwm  [NCH];

  bytebeat_audio_out #(
    .NCH  (4),
    .SW   (8),
    .DIV_W(9)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .div_i         (div),
    .mode_i        (mode),
    .sel_i         (sel),
    .pcm_in_i      (pcm_in),
    .pcm_vld_i     (pcm_vld),
    .pcm_rdy_o     (pcm_rdy),
    .clr_underrun_i(clr),
    .tick_o        (tick),
    .pwm_out_o     (pwm),
    .underrun_o    (und)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0;
    m_tick = 0;
    m_car  = 0;
    for (int i = 0; i < NCH; i++) begin
      m_full[i] = 0; m_buf[i] = 0; m_act[i] = 128;
      m_und[i]  = 0; m_lvl[i] = 128; m_pwm[i] = 0;
    end
  endtask

  function automatic logic [3:0] pack(input bit v [NCH]);
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = v[i];
    return r;
  endfunction

  // Advance the model by one clock using the inputs now applied, then clock the
  // DUT and compare all observable outputs.
  task automatic step();
    int tgt [NCH];
    int sum;
    bit f;
    logic [3:0] rdy_exp;
    sum = 0;
    for (int i = 0; i < NCH; i++) sum += m_act[i];
    for (int i = 0; i < NCH; i++) begin
      case (mode)
        2'd0:    tgt[i] = m_act[i];
        2'd1:    tgt[i] = m_act[sel];
        2'd2:    tgt[i] = sum / NCH;
        default: tgt[i] = 128;
      endcase
      m_pwm[i] = m_car < m_lvl[i];
      if (m_car == 255) m_lvl[i] = tgt[i];
    end
    for (int i = 0; i < NCH; i++) begin
      f = m_full[i];
      if (m_tick && f) begin
        m_act[i] = m_buf[i]; m_full[i] = 0;
      end else if (pcm_vld[i] && !f) begin
        m_buf[i] = pcm_in[i*8 +: 8]; m_full[i] = 1;
      end
      if (clr) m_und[i] = 0;
      if (m_tick && !f) m_und[i] = 1;
    end
    if (m_tcnt >= int'(div)) begin
      m_tcnt = 0; m_tick = 1;
    end else begin
      m_tcnt++; m_tick = 0;
    end
    m_car = (m_car + 1) % 256;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) rdy_exp[i] = !m_full[i];
    chk("cyc_tick", {31'd0, tick}, {31'd0, m_tick});
    chk("cyc_rdy", {28'd0, pcm_rdy}, {28'd0, rdy_exp});
    chk("cyc_pwm", {28'd0, pwm}, {28'd0, pack(m_pwm)});
    chk("cyc_underrun", {28'd0, und}, {28'd0, pack(m_und)});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Let levels settle, then count high cycles per channel over one period.
  task automatic duty4(input string tag, input int e0, input int e1, input int e2, input int e3);
    int cnt [NCH];
    run(300);
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      for (int i = 0; i < NCH; i++) cnt[i] += int'(pwm[i]);
    end
    chk({tag, "_ch0"}, cnt[0], e0);
    chk({tag, "_ch1"}, cnt[1], e1);
    chk({tag, "_ch2"}, cnt[2], e2);
    chk({tag, "_ch3"}, cnt[3], e3);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk(tag, {31'd0, tick}, 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    div     = 9'd3;
    mode    = 2'd0;
    sel     = 2'd0;
    pcm_in  = '0;
    pcm_vld = '0;
    clr     = 1'b0;
    model_reset();

    // 1. Reset values, tick cadence, midpoint duty
    #2;
    chk("rst_rdy", {28'd0, pcm_rdy}, 32'hf);
    chk("rst_pwm", {28'd0, pwm}, 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'h0);
    chk("rst_underrun", {28'd0, und}, 32'h0);
    #6 rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("t1_tick_cadence", {31'd0, tick}, {31'd0, (n % 4) == 0});
    end
    duty4("t1_mid_duty", 128, 128, 128, 128);

    // 2. Handshake on ch0, kept fed so it never underruns
    pcm_in  = 32'h0000_0040;
    pcm_vld = 4'b0001;
    step();
    chk("t2_rdy_after_accept", {31'd0, pcm_rdy[0]}, 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    duty4("t2_duty", 64, 128, 128, 128);
    chk("t2_no_underrun", {31'd0, und[0]}, 32'd0);

    // 3. Underrun on ch1: set, clear, clear coincident with tick
    wait_tick("t3_tick_seen");
    step();
    chk("t3_underrun_set", {31'd0, und[1]}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_underrun_cleared", {31'd0, und[1]}, 32'd0);
    wait_tick("t3_tick_seen2");
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_clear_loses", {31'd0, und[1]}, 32'd1);

    // 4. SELECT and MIX, then mid-period mode change
    pcm_in  = 32'h0000_FFFF;
    pcm_vld = 4'b1111;
    mode    = 2'd1;
    sel     = 2'd2;
    duty4("t4_select", 0, 0, 0, 0);
    mode = 2'd2;
    duty4("t4_mix", 127, 127, 127, 127);
    begin
      int n;
      n = 0;
      while (m_car != 150 && n < 300) begin
        step();
        n++;
      end
    end
    mode = 2'd0;
    step();
    chk("t4_midperiod_hold", {31'd0, pwm[0]}, 32'd0);
    duty4("t4_direct", 255, 255, 0, 0);

    // 5. Edge levels and MUTE
    pcm_in = 32'h0000_0000;
    duty4("t5_level0", 0, 0, 0, 0);
    pcm_in = 32'h0000_00FF;
    duty4("t5_levelff", 255, 0, 0, 0);
    mode = 2'd3;
    duty4("t5_mute", 128, 128, 128, 128);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      pcm_vld = 4'($urandom);
      pcm_in  = $urandom;
      clr     = ($urandom_range(0, 19) == 0);
      if (k % 300 == 0) begin
        mode = 2'($urandom_range(0, 3));
        sel  = 2'($urandom_range(0, 3));
        div  = 9'($urandom_range(0, 7));
      end
      step();
    end
    clr = 1'b0;

    // 6. Divider change, div=0, async reset
    div = 9'd10;
    begin
      int n;
      n = 0;
      while (m_tcnt != 7 && n < 32) begin
        step();
        n++;
      end
    end
    div = 9'd2;
    step();
    chk("t6_shrink_tick", {31'd0, tick}, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t6_period3", {31'd0, tick}, {31'd0, (k % 3) == 0});
    end
    div = 9'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t6_div0", {31'd0, tick}, 32'd1);
    end
    pcm_vld = 4'b1111;
    mode    = 2'd0;
    run(20);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_pwm", {28'd0, pwm}, 32'h0);
    chk("t6_async_rdy", {28'd0, pcm_rdy}, 32'hf);
    chk("t6_async_tick", {31'd0, tick}, 32'h0);
    model_reset();
    pcm_vld = '0;
    #2 rst_n = 1'b1;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bytebeat_audio_out.md
Name: bytebeat_audio_out

Overview:
Parametrised multi-channel PCM-to-PWM output stage for bytebeat generators.
- Replaces per-design ad-hoc clock division with a programmable sample-rate tick, used as a clock enable by generators.
- Adds per-channel one-entry sample buffers with valid/ready handshake and sticky underrun flags.
- Adds output modes (direct, select, mix, mute) with glitch-free level update at PWM carrier wrap.
- Sits between the generator bank and the uo_out pins.

Parameters:
NCH, 8, channel count; power of 2, 2..8.
SW, 8, sample and PWM resolution in bits; carrier period is 2^SW clk cycles.
DIV_W, 9, width of the sample-tick divider.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
div  in  DIV_W  sample tick period minus 1
mode  in  2  0 DIRECT, 1 SELECT, 2 MIX, 3 MUTE
sel  in  $clog2(NCH)  channel used in SELECT mode
pcm_in  in  NCH*SW  packed samples; channel i at [i*SW +: SW]
pcm_vld  in  NCH  per-channel sample valid
pcm_rdy  out  NCH  per-channel ready; equals !full[i]
clr_underrun  in  1  one-cycle clear of all underrun flags
tick  out  1  one-cycle sample strobe; clock enable for generators
pwm_out  out  NCH  registered PWM outputs
underrun  out  NCH  sticky per-channel underrun flags

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Reset values:
- Tick counter 0, tick 0.
- Carrier 0, pwm_out all 0.
- Buffers empty, so pcm_rdy all 1.
- Active samples and levels at MID = 1<<(SW-1).
- underrun all 0.

Tick generator:
- tcnt increments each clk.
- When tcnt >= div: tick=1 (registered), tcnt wraps to 0.
- The >= compare makes a shrinking div wrap on the next cycle.
- div=0 gives tick every cycle.
- Period is div+1 cycles. The first tick after reset is asserted in cycle div+1.

Sample slot, per channel:
- Accept when pcm_vld[i] && pcm_rdy[i]. The sample is stored in buf[i]; full[i] is set next cycle.
- On tick with full[i]=1: active[i] <= buf[i]; full[i] cleared.
- On tick with full[i]=0: active[i] holds; underrun[i] set.
- Tick and accept in the same cycle with the slot empty:
  - the sample goes into buf[i], with no bypass to active;
  - underrun[i] is still set.
- Tick with the slot full: rdy is 0, so no accept is possible; buf drains.
- clr_underrun clears all flags. A new underrun in the same cycle wins (flag stays 1).

Level selection:
- Target level per channel by mode:
  - DIRECT: active[i].
  - SELECT: active[sel] on every channel.
  - MIX: (sum of all active) >> log2(NCH) on every channel; sum width SW+log2(NCH); truncating average.
  - MUTE: MID on every channel.
- level[i] loads the target only in the cycle carrier == 2^SW-1.
- Mode, sel and sample changes therefore take effect at the next carrier period boundary, never mid-period.

PWM:
- carrier is a free-running SW-bit counter that wraps naturally.
- pwm_out[i] <= (carrier < level[i]), registered, 1-cycle latency.
- Level 0 gives a constant 0.
- Level 2^SW-1 gives a waveform that is low for exactly 1 cycle per period.
- Duty is level / 2^SW.

Reset mid-operation:
- All state returns to reset values immediately and asynchronously.
- Buffered samples are discarded.

Decomposition:
- Package bytebeat_audio_pkg:
  - mode enum: MODE_DIRECT, MODE_SELECT, MODE_MIX, MODE_MUTE;
  - mid-level function of SW;
  - sample index helper for packed buses.
- Sub-module bytebeat_sample_slot, generated NCH times:
  - buf, full, active, underrun flag;
  - inputs tick, vld, data, clr;
  - outputs rdy, active, underrun.
- Tick generator, mixer and PWM compare stay in the top.

Test Plan:
1. Reset and midpoint, with NCH=4, SW=8, div=3.
   - Stimulus: release reset.
   - Response: pcm_rdy=4'b1111; tick in cycles 4, 8, 12; each pwm_out high 128 of every 256 cycles starting one carrier period after release.
2. Handshake.
   - Stimulus: ch0 vld with 0x40 in cycle 1.
   - Response: pcm_rdy[0]=0 from cycle 2 until the cycle after the next tick; after the following carrier wrap, pwm_out[0] duty is 64/256; underrun[0] stays 0.
3. Underrun.
   - Stimulus: no vld on ch1 across a tick; then clr_underrun pulse; then clr_underrun coincident with a tick while ch1 is empty.
   - Response: underrun[1]=1 and ch1 level held; cleared to 0 by the pulse; with the coincident clear, flag remains 1.
4. SELECT and MIX.
   - Stimulus: samples 0xFF, 0xFF, 0x00, 0x00.
   - Response: mode=1, sel=2 gives all outputs duty 0 (constant low); mode=2 gives all outputs level 0x7F (510>>2).
   - Stimulus: mode change issued mid-period.
   - Response: outputs change only at the carrier wrap.
5. Edge levels and MUTE.
   - Stimulus: level 0x00; level 0xFF; mode=3.
   - Response: 0x00 gives pwm_out constant 0; 0xFF gives exactly 1 low cycle per 256; mode=3 gives duty 128/256 on every channel regardless of samples.
6. Divider change.
   - Stimulus: div changed from 10 to 2 while tcnt=7.
   - Response: tick asserted next cycle, then every 3 cycles.
   - Stimulus: div=0.
   - Response: tick continuous.
   - Stimulus: async reset asserted mid-stream.
   - Response: pwm_out=0 and pcm_rdy all 1 without waiting for a clk edge.
